// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the dcache port arbiter: FSM states, CACOP op codes and the
// layout of the latched request.
package dcache_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPipeRd = 3'd1,
    StPipeWr = 3'd2,
    StCacop  = 3'd3,
    StDrain  = 3'd4,
    StResp   = 3'd5
  } dpa_state_e;

  typedef enum logic [1:0] {
    CacopIdxInit = 2'd0,
    CacopIdxInv  = 2'd1,
    CacopHitInv  = 2'd2,
    CacopRsvd    = 2'd3
  } cacop_type_e;

  // Address is shared between the pipe access and the CACOP target.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    cacop_type_e cacop_type;
  } dpa_req_t;

  function automatic logic [3:0] store_mask(input logic is_write, input logic [3:0] wstrb);
    return is_write ? wstrb : 4'b0000;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_req_hold.sv
// Enable-loaded holding register for the granted request; keeps dc_* stable
// until the dcache handshakes.
module dcache_port_arbiter_req_hold
  import dcache_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     aresetn,
  input  logic     load,
  input  dpa_req_t d,
  output dpa_req_t q
);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache port between EX1 loads/stores and the CACOP engine,
// with starvation protection for the pipe and flush draining.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        flush,
  input  logic        pipe_rvalid,
  input  logic        pipe_wvalid,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic [3:0]  pipe_wstrb,
  input  logic        pipe_atom,
  output logic        pipe_done,
  output logic [31:0] pipe_rdata,
  output logic        mem_stall,
  input  logic        cacop_en,
  input  logic [1:0]  cacop_type,
  input  logic [31:0] cacop_vaddr,
  output logic        cacop_done,
  output logic        dc_rvalid,
  output logic        dc_wvalid,
  output logic        dc_op,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  output logic [3:0]  dc_wstrb,
  output logic        dc_atom,
  input  logic        dc_rready,
  input  logic [31:0] dc_rdata,
  input  logic        dc_wready,
  output logic        dc_cacop_en,
  output logic [1:0]  dc_cacop_type,
  output logic [31:0] dc_cacop_vaddr,
  input  logic        dc_cacop_done
);

  localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_MAX);

  dpa_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_pipe_q, owner_pipe_d;
  logic              flushed_q, flushed_d;
  logic              atom_q, atom_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              hold_load;
  dpa_req_t          hold_d, hold_q;
  logic              pipe_req;

  // A request arriving together with a flush belongs to a squashed instruction.
  assign pipe_req = (pipe_rvalid | pipe_wvalid) & ~flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_pipe_d = owner_pipe_q;
    flushed_d    = flushed_q;
    atom_d       = atom_q;
    rdata_d      = rdata_q;
    hold_load    = 1'b0;
    hold_d       = '0;
    pipe_done    = 1'b0;
    cacop_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cacop_en && (!pipe_req || (cnt_q < StarveLim))) begin
          state_d           = StCacop;
          owner_pipe_d      = 1'b0;
          atom_d            = 1'b0;
          hold_load         = 1'b1;
          hold_d.addr       = cacop_vaddr;
          hold_d.cacop_type = cacop_type_e'(cacop_type);
          if (pipe_req) cnt_d = cnt_q + CNT_W'(1);
        end else if (pipe_req) begin
          state_d      = pipe_wvalid ? StPipeWr : StPipeRd;
          owner_pipe_d = 1'b1;
          flushed_d    = 1'b0;
          atom_d       = pipe_atom;
          hold_load    = 1'b1;
          hold_d.addr  = pipe_addr;
          hold_d.wdata = pipe_wvalid ? pipe_wdata : 32'd0;
          hold_d.wstrb = store_mask(pipe_wvalid, pipe_wstrb);
          cnt_d        = '0;
        end
      end
      StPipeRd: begin
        if (flush) flushed_d = 1'b1;
        if (dc_rready) begin
          if (flushed_q || flush) begin
            state_d = StDrain;
          end else begin
            rdata_d = dc_rdata;
            state_d = StResp;
          end
        end
      end
      StPipeWr: begin
        if (flush) flushed_d = 1'b1;
        if (dc_wready) state_d = (flushed_q || flush) ? StDrain : StResp;
      end
      StCacop: begin
        if (dc_cacop_done) state_d = StResp;
      end
      StDrain: state_d = StIdle;
      StResp: begin
        state_d = StIdle;
        if (owner_pipe_q) pipe_done = ~flush;
        else              cacop_done = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_pipe_q <= 1'b0;
      flushed_q    <= 1'b0;
      atom_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_pipe_q <= owner_pipe_d;
      flushed_q    <= flushed_d;
      atom_q       <= atom_d;
      rdata_q      <= rdata_d;
    end
  end

  dcache_port_arbiter_req_hold u_req_hold (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (hold_load),
    .d       (hold_d),
    .q       (hold_q)
  );

  assign dc_rvalid      = (state_q == StPipeRd);
  assign dc_wvalid      = (state_q == StPipeWr);
  assign dc_cacop_en    = (state_q == StCacop);
  assign dc_op          = dc_wvalid;
  assign dc_addr        = hold_q.addr;
  assign dc_wdata       = hold_q.wdata;
  assign dc_wstrb       = dc_wvalid ? hold_q.wstrb : 4'b0000;
  assign dc_atom        = atom_q & (dc_rvalid | dc_wvalid);
  assign dc_cacop_type  = hold_q.cacop_type;
  assign dc_cacop_vaddr = hold_q.addr;
  assign pipe_rdata     = rdata_q;
  assign mem_stall      = (pipe_rvalid | pipe_wvalid) & ~pipe_done;

  // Simultaneous load and store from EX1 is illegal; the store wins above.
  ap_single_pipe_req: assert property (@(posedge clk) disable iff (!aresetn)
    !(pipe_rvalid && pipe_wvalid));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: load/store handshakes, CACOP priority and
// starvation limit, flush draining and asynchronous reset.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        pipe_rvalid, pipe_wvalid;
  logic [31:0] pipe_addr, pipe_wdata;
  logic [3:0]  pipe_wstrb;
  logic        pipe_atom;
  logic        pipe_done;
  logic [31:0] pipe_rdata;
  logic        mem_stall;
  logic        cacop_en;
  logic [1:0]  cacop_type;
  logic [31:0] cacop_vaddr;
  logic        cacop_done;
  logic        dc_rvalid, dc_wvalid, dc_op;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_atom;
  logic        dc_rready;
  logic [31:0] dc_rdata;
  logic        dc_wready;
  logic        dc_cacop_en;
  logic [1:0]  dc_cacop_type;
  logic [31:0] dc_cacop_vaddr;
  logic        dc_cacop_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .flush          (flush),
    .pipe_rvalid    (pipe_rvalid),
    .pipe_wvalid    (pipe_wvalid),
    .pipe_addr      (pipe_addr),
    .pipe_wdata     (pipe_wdata),
    .pipe_wstrb     (pipe_wstrb),
    .pipe_atom      (pipe_atom),
    .pipe_done      (pipe_done),
    .pipe_rdata     (pipe_rdata),
    .mem_stall      (mem_stall),
    .cacop_en       (cacop_en),
    .cacop_type     (cacop_type),
    .cacop_vaddr    (cacop_vaddr),
    .cacop_done     (cacop_done),
    .dc_rvalid      (dc_rvalid),
    .dc_wvalid      (dc_wvalid),
    .dc_op          (dc_op),
    .dc_addr        (dc_addr),
    .dc_wdata       (dc_wdata),
    .dc_wstrb       (dc_wstrb),
    .dc_atom        (dc_atom),
    .dc_rready      (dc_rready),
    .dc_rdata       (dc_rdata),
    .dc_wready      (dc_wready),
    .dc_cacop_en    (dc_cacop_en),
    .dc_cacop_type  (dc_cacop_type),
    .dc_cacop_vaddr (dc_cacop_vaddr),
    .dc_cacop_done  (dc_cacop_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0; flush = 1'b0;
    pipe_rvalid = 1'b0; pipe_wvalid = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    pipe_wstrb = '0; pipe_atom = 1'b0;
    cacop_en = 1'b0; cacop_type = '0; cacop_vaddr = '0;
    dc_rready = 1'b0; dc_rdata = '0; dc_wready = 1'b0; dc_cacop_done = 1'b0;
    #3;
    chk("rst_dc_rvalid", 32'(dc_rvalid), 32'd0);
    chk("rst_dc_wvalid", 32'(dc_wvalid), 32'd0);
    chk("rst_dc_cacop_en", 32'(dc_cacop_en), 32'd0);
    chk("rst_pipe_done", 32'(pipe_done), 32'd0);
    chk("rst_cacop_done", 32'(cacop_done), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_pipe_rdata", pipe_rdata, 32'd0);
    tick(); tick();
    aresetn = 1'b1;

    // 1: load, read data two cycles after dc_rvalid
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_1000;
    #1;
    chk("t1_stall_req", 32'(mem_stall), 32'd1);
    tick();
    chk("t1_rvalid", 32'(dc_rvalid), 32'd1);
    chk("t1_addr", dc_addr, 32'h0000_1000);
    chk("t1_op", 32'(dc_op), 32'd0);
    chk("t1_wstrb", 32'(dc_wstrb), 32'd0);
    tick();
    chk("t1_rvalid_wait", 32'(dc_rvalid), 32'd1);
    tick();
    dc_rready = 1'b1; dc_rdata = 32'hDEAD_BEEF;
    tick();
    dc_rready = 1'b0; dc_rdata = '0;
    chk("t1_done", 32'(pipe_done), 32'd1);
    chk("t1_rdata", pipe_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_done", 32'(mem_stall), 32'd0);
    chk("t1_rvalid_fall", 32'(dc_rvalid), 32'd0);
    pipe_rvalid = 1'b0;
    tick();
    chk("t1_done_pulse", 32'(pipe_done), 32'd0);

    // 2: store 0x2004 wstrb 0011, dc_wready withheld for 5 cycles
    pipe_wvalid = 1'b1; pipe_addr = 32'h0000_2004; pipe_wdata = 32'h1234_5678;
    pipe_wstrb = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_wvalid", 32'(dc_wvalid), 32'd1);
      chk("t2_addr", dc_addr, 32'h0000_2004);
      chk("t2_wdata", dc_wdata, 32'h1234_5678);
      chk("t2_wstrb", 32'(dc_wstrb), 32'h3);
      chk("t2_no_done", 32'(pipe_done), 32'd0);
      tick();
    end
    chk("t2_op", 32'(dc_op), 32'd1);
    dc_wready = 1'b1;
    tick();
    dc_wready = 1'b0;
    chk("t2_done", 32'(pipe_done), 32'd1);
    chk("t2_wvalid_fall", 32'(dc_wvalid), 32'd0);
    pipe_wvalid = 1'b0; pipe_wstrb = '0; pipe_wdata = '0;
    tick();
    chk("t2_single_done", 32'(pipe_done), 32'd0);

    // 3: CACOP and load together, CACOP first
    cacop_en = 1'b1; cacop_type = 2'd2; cacop_vaddr = 32'h0000_3000;
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_4000;
    tick();
    cacop_en = 1'b0;
    chk("t3_cacop_en", 32'(dc_cacop_en), 32'd1);
    chk("t3_no_rvalid", 32'(dc_rvalid), 32'd0);
    chk("t3_vaddr", dc_cacop_vaddr, 32'h0000_3000);
    chk("t3_type", 32'(dc_cacop_type), 32'd2);
    dc_cacop_done = 1'b1;
    tick();
    dc_cacop_done = 1'b0;
    chk("t3_cacop_done", 32'(cacop_done), 32'd1);
    chk("t3_no_pipe_done", 32'(pipe_done), 32'd0);
    chk("t3_cacop_en_fall", 32'(dc_cacop_en), 32'd0);
    tick();
    chk("t3_idle_no_rvalid", 32'(dc_rvalid), 32'd0);
    chk("t3_cacop_done_pulse", 32'(cacop_done), 32'd0);
    tick();
    chk("t3_pipe_rvalid", 32'(dc_rvalid), 32'd1);
    chk("t3_pipe_addr", dc_addr, 32'h0000_4000);
    dc_rready = 1'b1; dc_rdata = 32'hCAFE_F00D;
    tick();
    dc_rready = 1'b0;
    chk("t3_pipe_done", 32'(pipe_done), 32'd1);
    chk("t3_pipe_rdata", pipe_rdata, 32'hCAFE_F00D);
    pipe_rvalid = 1'b0;
    tick();

    // 4: continuous CACOP with a load waiting; load wins after four CACOPs
    cacop_en = 1'b1; cacop_type = 2'd1; cacop_vaddr = 32'h0000_3100;
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_cacop_grant", 32'(dc_cacop_en), 32'd1);
      chk("t4_pipe_held_off", 32'(dc_rvalid), 32'd0);
      chk("t4_stall", 32'(mem_stall), 32'd1);
      dc_cacop_done = 1'b1;
      tick();
      dc_cacop_done = 1'b0;
      chk("t4_cacop_done", 32'(cacop_done), 32'd1);
      tick();
    end
    tick();
    chk("t4_pipe_grant", 32'(dc_rvalid), 32'd1);
    chk("t4_no_cacop", 32'(dc_cacop_en), 32'd0);
    chk("t4_addr", dc_addr, 32'h0000_5000);
    cacop_en = 1'b0;
    dc_rready = 1'b1; dc_rdata = 32'h0BAD_CAFE;
    tick();
    dc_rready = 1'b0;
    chk("t4_pipe_done", 32'(pipe_done), 32'd1);
    chk("t4_rdata", pipe_rdata, 32'h0BAD_CAFE);
    pipe_rvalid = 1'b0;
    tick();

    // 5: flush in IDLE blocks grant; flush after launch drains
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_6000; flush = 1'b1;
    tick();
    chk("t5_idle_flush_no_grant", 32'(dc_rvalid), 32'd0);
    flush = 1'b0;
    tick();
    chk("t5_launch", 32'(dc_rvalid), 32'd1);
    tick();
    flush = 1'b1; pipe_rvalid = 1'b0;
    tick();
    flush = 1'b0;
    chk("t5_held", 32'(dc_rvalid), 32'd1);
    chk("t5_addr_held", dc_addr, 32'h0000_6000);
    tick();
    dc_rready = 1'b1; dc_rdata = 32'h0000_BAD0;
    tick();
    dc_rready = 1'b0;
    chk("t5_drain_no_done", 32'(pipe_done), 32'd0);
    chk("t5_drain_rvalid", 32'(dc_rvalid), 32'd0);
    chk("t5_drain_discard", pipe_rdata, 32'h0BAD_CAFE);
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_7000;
    tick();
    chk("t5_post_drain_no_done", 32'(pipe_done), 32'd0);
    chk("t5_post_drain_no_grant", 32'(dc_rvalid), 32'd0);
    tick();
    chk("t5_regrant", 32'(dc_rvalid), 32'd1);
    chk("t5_regrant_addr", dc_addr, 32'h0000_7000);
    dc_rready = 1'b1; dc_rdata = 32'h7777_7777;
    tick();
    dc_rready = 1'b0; flush = 1'b1;
    #1;
    chk("t5_resp_flush_no_done", 32'(pipe_done), 32'd0);
    flush = 1'b0; pipe_rvalid = 1'b0;
    tick();

    // 6: asynchronous reset in the middle of a store
    pipe_wvalid = 1'b1; pipe_addr = 32'h0000_8000; pipe_wdata = 32'hA5A5_A5A5;
    pipe_wstrb = 4'b1111; pipe_atom = 1'b1;
    tick();
    chk("t6_wvalid", 32'(dc_wvalid), 32'd1);
    chk("t6_atom", 32'(dc_atom), 32'd1);
    tick();
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_async_wvalid", 32'(dc_wvalid), 32'd0);
    chk("t6_async_addr", dc_addr, 32'd0);
    chk("t6_async_atom", 32'(dc_atom), 32'd0);
    pipe_wvalid = 1'b0; pipe_atom = 1'b0; pipe_wstrb = '0;
    tick();
    aresetn = 1'b1;
    tick();
    chk("t6_idle_wvalid", 32'(dc_wvalid), 32'd0);
    chk("t6_idle_rvalid", 32'(dc_rvalid), 32'd0);
    pipe_rvalid = 1'b1; pipe_addr = 32'h0000_9000;
    tick();
    chk("t6_new_grant", 32'(dc_rvalid), 32'd1);
    chk("t6_new_addr", dc_addr, 32'h0000_9000);
    dc_rready = 1'b1; dc_rdata = 32'h9999_0000;
    tick();
    dc_rready = 1'b0;
    chk("t6_new_done", 32'(pipe_done), 32'd1);
    chk("t6_new_rdata", pipe_rdata, 32'h9999_0000);
    pipe_rvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
